// File: rtl/filtered_fifo_arbiter_pkg.sv
// Shared types and helpers for the filtered FIFO write-port arbiter.
package filtered_fifo_arb_pkg;

    // Wide enough for the largest supported producer count (16).
    localparam int unsigned GRANT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef logic [GRANT_W-1:0] grant_idx_t;

    function automatic grant_idx_t next_rr(
        input grant_idx_t  ptr,
        input int unsigned num_req
    );
        if (32'(ptr) + 32'd1 >= num_req) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/filtered_fifo_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after start, with wrap.
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW:0] j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = {1'b0, start} + (IW+1)'(k);
            if (j >= (IW+1)'(N)) begin
                j = j - (IW+1)'(N);
            end
            if (!found && j < (IW+1)'(N) && req[j[IW-1:0]]) begin
                found = 1'b1;
                idx   = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/filtered_fifo_arbiter.sv
// Round-robin, packet-locked arbiter in front of a multi-lane filtered FIFO.
// Define FILTERED_FIFO_ARB_STATS_EN to add per-producer beat/element counters.
module filtered_fifo_arbiter
    import filtered_fifo_arb_pkg::*;
#(
    parameter  int BIT_WIDTH  = 32,
    parameter  int MAX_INPUTS = 4,
    parameter  int NUM_REQ    = 4,
    parameter  int MAX_BURST  = 8,
    localparam int IW         = $clog2(NUM_REQ),
    localparam int CW         = $clog2(MAX_BURST + 1),
    localparam int DW         = MAX_INPUTS * BIT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DW-1:0]         req_data,
    input  logic [NUM_REQ*MAX_INPUTS-1:0] req_keep,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          ff_valid,
    output logic [DW-1:0]                 ff_data,
    output logic [MAX_INPUTS-1:0]         ff_keep,
    input  logic                          ff_ready,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy
`ifdef FILTERED_FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]         stat_beats,
    output logic [NUM_REQ*32-1:0]         stat_elems,
    input  logic                          stat_clr
`endif
);

    arb_state_t state;
    arb_state_t state_nx;

    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         grant_q;
    logic [CW-1:0]         beat_cnt;
    logic                  pick_found;
    logic [IW-1:0]         pick_idx;
    logic [DW-1:0]         g_data;
    logic [MAX_INPUTS-1:0] g_keep;
    logic                  g_valid;
    logic                  g_last;
    logic                  g_rdy;
    logic                  accept;
    logic                  release_g;

    rr_picker #(
        .N (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .start (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        g_data  = '0;
        g_keep  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_q == IW'(r)) begin
                g_data  = req_data[r*DW +: DW];
                g_keep  = req_keep[r*MAX_INPUTS +: MAX_INPUTS];
                g_valid = req_valid[r];
                g_last  = req_last[r];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        ff_valid  = 1'b0;
        ff_data   = '0;
        ff_keep   = '0;
        g_rdy     = 1'b0;
        accept    = 1'b0;
        release_g = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                // An all-empty beat never reaches the FIFO; it is dropped here.
                if (|g_keep) begin
                    ff_valid = g_valid;
                    ff_data  = g_valid ? g_data : '0;
                    ff_keep  = g_valid ? g_keep : '0;
                    g_rdy    = ff_ready;
                end else begin
                    g_rdy    = 1'b1;
                end
                req_ready = NUM_REQ'(g_rdy) << grant_q;
                accept    = g_valid & g_rdy;
                release_g = accept &
                            (g_last | (beat_cnt == CW'(MAX_BURST - 1)));
                if (release_g) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_q  <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && pick_found) begin
                grant_q  <= pick_idx;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (release_g) begin
                rr_ptr <= IW'(next_rr(grant_idx_t'(grant_q),
                                      $unsigned(NUM_REQ)));
            end
        end
    end

    assign busy     = (state == GRANT);
    assign grant_id = grant_q;

`ifdef FILTERED_FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] beats_q;
    logic [NUM_REQ-1:0][31:0] elems_q;
    logic [31:0]              pop;

    always_comb begin
        pop = 32'($countones(ff_keep));
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            beats_q <= '0;
            elems_q <= '0;
        end else if (ff_valid && ff_ready) begin
            beats_q[grant_q] <= beats_q[grant_q] + 32'd1;
            elems_q[grant_q] <= elems_q[grant_q] + pop;
        end
    end

    assign stat_beats = beats_q;
    assign stat_elems = elems_q;
`endif

endmodule

// File: doc/filtered_fifo_arbiter.md
Name: filtered_fifo_arbiter

Overview:
- Shares one multi-lane filtered FIFO write port among NUM_REQ independent producers.
- Each producer offers beats of MAX_INPUTS lanes with a per-lane keep mask.
- Round-robin arbitration with packet locking: a grant holds until the producer's last beat or until MAX_BURST beats are consumed.
- Sits directly upstream of the filtered FIFO input (valid/data/keep/ready).

Parameters:
- BIT_WIDTH, 32, lane width in bits.
- MAX_INPUTS, 4, lanes per beat; even, >0.
- NUM_REQ, 4, number of producers; 2..16.
- MAX_BURST, 8, maximum beats per grant before forced rotation; >=1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  NUM_REQ  per-producer beat valid.
- req_data  in  NUM_REQ*MAX_INPUTS*BIT_WIDTH  producer r, lane i at bits [(r*MAX_INPUTS+i)*BIT_WIDTH +: BIT_WIDTH].
- req_keep  in  NUM_REQ*MAX_INPUTS  producer r lane keep at [r*MAX_INPUTS +: MAX_INPUTS].
- req_last  in  NUM_REQ  final beat of producer's packet.
- req_ready  out  NUM_REQ  beat accepted when req_valid&req_ready.
- ff_valid  out  1  to FIFO in_valid.
- ff_data  out  MAX_INPUTS*BIT_WIDTH  to FIFO in_data (lane i at [i*BIT_WIDTH +: BIT_WIDTH]).
- ff_keep  out  MAX_INPUTS  to FIFO in_keep.
- ff_ready  in  1  FIFO in_ready.
- grant_id  out  $clog2(NUM_REQ)  current/last granted producer.
- busy  out  1  high in GRANT state.

Behaviour:
- Reset is synchronous, active-high on rst, clock clk.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - busy=0, ff_valid=0, req_ready=0, ff_keep=0, ff_data=0.
- States:
  - IDLE: combinational round-robin pick of the first r with req_valid[r], searching from rr_ptr upward with wrap.
    - If any is found: register grant_id=r, beat_cnt=0, go to GRANT next cycle.
    - One cycle of arbitration latency; no data passes in IDLE.
  - GRANT: zero-latency combinational forwarding from producer g=grant_id.
    - If keep_g!=0: ff_valid=req_valid[g], ff_data/ff_keep=producer g's data/keep, req_ready[g]=ff_ready.
    - If keep_g==0: beat is consumed locally. req_ready[g]=1, ff_valid=0. The beat counts toward beat_cnt and honours req_last.
    - req_ready of all other producers is 0.
    - On each accepted beat: beat_cnt++.
    - Release when the accepted beat has req_last=1, or beat_cnt+1==MAX_BURST. On release: rr_ptr=(g+1) mod NUM_REQ, go to IDLE.
    - If req_valid[g] drops while granted: stay in GRANT (packet lock); no timeout.
- ff_valid is never asserted while ff_keep==0.
- ff_data/ff_keep are 0 whenever ff_valid=0.
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr wraps explicitly modulo NUM_REQ; non-power-of-2 NUM_REQ must not select an invalid index.
- Backpressure: while ff_ready=0, the grant holds and beat_cnt is unchanged.
- Simultaneous requests in IDLE: rr_ptr order only; a producer that just released has lowest priority next.
- Reset mid-packet: grant is dropped immediately; the producer's partial packet is the producer's responsibility.
- grant_id holds its value in IDLE.

Optional Feature:
- Macro FILTERED_FIFO_ARB_STATS_EN.
- When defined, adds:
  - Output stat_beats, NUM_REQ*32: per-producer count of beats forwarded to the FIFO.
  - Output stat_elems, NUM_REQ*32: per-producer sum of popcount(ff_keep) of forwarded beats.
  - Input stat_clr, 1: synchronous clear of both counters, priority over increment in the same cycle.
- Counters wrap at 2^32. Both reset to 0.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package filtered_fifo_arb_pkg:
  - state enum {IDLE, GRANT}.
  - typedef for grant index.
  - function next_rr(ptr, NUM_REQ) for modular increment.
- Sub-module rr_picker: combinational, req vector + start pointer -> found flag + index. Unit-tested standalone.

Test Plan:
- Single producer 0, 3-beat packet with keep=4'b1111 each beat, last on beat 3, ff_ready=1 -> 1 IDLE cycle, then 3 consecutive ff_valid beats; back in IDLE on cycle 5; rr_ptr=1.
- Producers 0,1,2 all valid with 1-beat packets from reset -> grant order 0,1,2, each separated by 1 idle cycle; grant_id sequence 0,1,2.
- Producer 3 streams 20 beats with no last, MAX_BURST=8, producer 1 also valid -> grant 3 for exactly 8 beats, then 1, then 3 again.
- Producer 2 beat with keep=0 between two keep=4'b0101 beats -> ff_valid high for only 2 beats; req_ready[2] high for all 3; beat_cnt=3.
- ff_ready low for 5 cycles mid-packet -> ff_valid/ff_data held stable, no req_ready, no grant change; resumes without loss.
- rst asserted during GRANT beat 2 -> next cycle busy=0, ff_valid=0, rr_ptr=0. With STATS_EN: stat_beats of the granted producer = beats forwarded before reset, then cleared to 0.
